// File: rtl/rule_confirm_pkg.sv
// Shared widths and field offsets for the rule confirm unit and the
// priority comparison engine that consumes its confirm words.
package rule_confirm_pkg;

    localparam int KWID    = 104;
    localparam int MASKWID = KWID / 8;
    localparam int IDWID   = 8;
    localparam int PRIOR   = 8;
    localparam int CFWID   = 1 + IDWID + PRIOR;
    localparam int TWID    = KWID + MASKWID + PRIOR;
    localparam int DEPTH   = 1 << IDWID;
    localparam int HITW    = 32;

    // Table word is {key, mask, prio}; confirm word is {match, ruleid, prio}.
    localparam int TW_PRIO_LSB  = 0;
    localparam int TW_MASK_LSB  = PRIOR;
    localparam int TW_KEY_LSB   = PRIOR + MASKWID;
    localparam int CF_PRIO_LSB  = 0;
    localparam int CF_ID_LSB    = PRIOR;
    localparam int CF_MATCH_BIT = PRIOR + IDWID;

endpackage

// File: rtl/rule_confirm_unit_ram.sv
// Simple dual-port rule table: synchronous read-first lookup, no data reset.
module rule_table_ram #(
    parameter int DW = rule_confirm_pkg::TWID,
    parameter int AW = rule_confirm_pkg::IDWID
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    // Both ports use non-blocking updates, so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/rule_confirm_unit.sv
// Three-stage rule confirm: S0 captures the request and reads the table,
// S1 compares with per-byte wildcards, S2 registers the confirm word.
module rule_confirm_unit #(
    parameter int KWID    = rule_confirm_pkg::KWID,
    parameter int MASKWID = KWID / 8,
    parameter int IDWID   = rule_confirm_pkg::IDWID,
    parameter int PRIOR   = rule_confirm_pkg::PRIOR,
    parameter int CFWID   = 1 + IDWID + PRIOR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [KWID-1:0]             i_key,
    input  logic                        i_cand_valid,
    input  logic [IDWID-1:0]            i_cand_id,
    input  logic                        i_wr_en,
    input  logic [IDWID-1:0]            i_wr_addr,
    input  logic                        i_wr_vld,
    input  logic [KWID+MASKWID+PRIOR-1:0] i_wr_data,
    output logic [CFWID-1:0]            o_confirm_result,
    output logic                        o_confirm_valid,
    output logic [31:0]                 o_hit_cnt
);

    import rule_confirm_pkg::*;

    localparam int TWORD_W  = KWID + MASKWID + PRIOR;
    localparam int DEPTH_N  = 1 << IDWID;
    localparam int MASK_LSB = PRIOR;
    localparam int KEY_LSB  = PRIOR + MASKWID;

    logic [DEPTH_N-1:0] ent_vld_q;
    logic               s0_vld_q;
    logic               s0_ent_vld_q;
    logic [KWID-1:0]    s0_key_q;
    logic [IDWID-1:0]   s0_id_q;
    logic [TWORD_W-1:0] rd_word;
    logic [MASKWID-1:0] byte_hit;
    logic               match;
    logic [CFWID-1:0]   result_d;
    logic [CFWID-1:0]   result_q;
    logic               valid_q;
    logic [31:0]        hit_cnt_d;
    logic [31:0]        hit_cnt_q;

    rule_table_ram #(
        .DW (TWORD_W),
        .AW (IDWID)
    ) u_table (
        .clk       (clk),
        .wr_en_i   (i_wr_en),
        .wr_addr_i (i_wr_addr),
        .wr_data_i (i_wr_data),
        .rd_addr_i (i_cand_id),
        .rd_data_o (rd_word)
    );

    // Entry valid bits live outside the RAM so reset can invalidate the whole table.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld_q    <= '0;
            s0_vld_q     <= 1'b0;
            s0_ent_vld_q <= 1'b0;
        end else begin
            if (i_wr_en) begin
                ent_vld_q[i_wr_addr] <= i_wr_vld;
            end
            s0_vld_q     <= i_cand_valid;
            s0_ent_vld_q <= ent_vld_q[i_cand_id];
        end
    end

    always_ff @(posedge clk) begin
        s0_key_q <= i_key;
        s0_id_q  <= i_cand_id;
    end

    always_comb begin
        byte_hit  = '0;
        for (int b = 0; b < MASKWID; b++) begin
            byte_hit[b] = rd_word[MASK_LSB + b] |
                          (s0_key_q[8*b +: 8] == rd_word[KEY_LSB + 8*b +: 8]);
        end
        match     = s0_vld_q & s0_ent_vld_q & (&byte_hit);
        result_d  = '0;
        hit_cnt_d = hit_cnt_q;
        if (match) begin
            result_d = {1'b1, s0_id_q, rd_word[PRIOR-1:0]};
            if (hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q  <= '0;
            valid_q   <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            result_q  <= result_d;
            valid_q   <= s0_vld_q;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign o_confirm_result = result_q;
    assign o_confirm_valid  = valid_q;
    assign o_hit_cnt        = hit_cnt_q;

endmodule
